// File: rtl/parking_timer_bank_if.sv
// parking_timer_bank_if: sensor-side and billing-side signal bundle of the parking timer bank.
//   start/stop  per-slot one-cycle pulses from the gate/slot sensors
//   rd_sel      slot index for the live count readout
//   pause       (only with PARKING_TIMER_PAUSE_EN) freezes the shared prescaler
//   rd_count    registered live count of slot rd_sel
//   tick        one-cycle prescaler pulse
//   running     per-slot "currently timing" flags
//   expired     per-slot sticky overstay flags
//   done_*      one-cycle final-duration report toward billing/display
interface parking_timer_bank_if #(
  parameter int NUM_SLOTS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 10
);
  logic [NUM_SLOTS-1:0] start;
  logic [NUM_SLOTS-1:0] stop;
  logic [SEL_W-1:0]     rd_sel;
`ifdef PARKING_TIMER_PAUSE_EN
  logic                 pause;
`endif
  logic [CNT_W-1:0]     rd_count;
  logic                 tick;
  logic [NUM_SLOTS-1:0] running;
  logic [NUM_SLOTS-1:0] expired;
  logic                 done_valid;
  logic [SEL_W-1:0]     done_slot;
  logic [CNT_W-1:0]     done_count;
`ifdef PARKING_TIMER_PAUSE_EN
  modport master (output start, stop, rd_sel, pause,
                  input rd_count, tick, running, expired, done_valid, done_slot, done_count);
  modport slave  (input start, stop, rd_sel, pause,
                  output rd_count, tick, running, expired, done_valid, done_slot, done_count);
`else
  modport master (output start, stop, rd_sel,
                  input rd_count, tick, running, expired, done_valid, done_slot, done_count);
  modport slave  (input start, stop, rd_sel,
                  output rd_count, tick, running, expired, done_valid, done_slot, done_count);
`endif
endinterface

// File: rtl/parking_timer_bank.sv
// parking_timer_bank: multi-slot parking-duration timer with shared prescaler and queued duration reports.
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   pif    parking_timer_bank_if.slave (start/stop/rd_sel[/pause] in; tick/running/expired/rd_count/done_* out)
// Optional feature: define PARKING_TIMER_PAUSE_EN to add the pause input that freezes the prescaler.
module parking_timer_bank #(
  parameter int NUM_SLOTS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 10,
  parameter int PRESCALE  = 100,
  parameter int MAX_TIME  = 600
) (
  input logic                 clk,
  input logic                 reset,
  parking_timer_bank_if.slave pif
);
  localparam int PW = $clog2(PRESCALE);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t                         state_q [NUM_SLOTS];
  state_t                         state_d [NUM_SLOTS];
  logic [PW-1:0]                  pre_q, pre_d;
  logic [NUM_SLOTS-1:0][CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d, upd;
  logic [NUM_SLOTS-1:0]           pend_q, pend_d, exp_q, exp_d;
  logic [CNT_W-1:0]               rd_q, rd_d, dc_q, dc_d;
  logic [SEL_W-1:0]               ds_q, ds_d, pick;
  logic                           dv_q, pick_v, pause, tick;
`ifdef PARKING_TIMER_PAUSE_EN
  assign pause = pif.pause;
`else
  assign pause = 1'b0;
`endif
  assign tick  = !pause && pre_q == PW'(PRESCALE - 1);
  assign pre_d = pause ? pre_q : tick ? '0 : pre_q + PW'(1);
  // Lowest pending index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    pick_v = 1'b0;
    pick   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (pend_q[i]) begin
        pick_v = 1'b1;
        pick   = SEL_W'(i);
      end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    exp_d   = exp_q;
    upd     = cnt_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      // Saturating increment; the snapshot on stop includes a coincident tick.
      upd[i] = (tick && cnt_q[i] != '1) ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      case (state_q[i])
        IDLE: if (pif.start[i]) begin
          cnt_d[i]   = '0;
          exp_d[i]   = 1'b0;
          state_d[i] = RUN;
        end
        RUN: begin
          cnt_d[i] = upd[i];
          if (32'(upd[i]) >= MAX_TIME) exp_d[i] = 1'b1;
          if (pif.stop[i]) begin
            snap_d[i]  = upd[i];
            pend_d[i]  = 1'b1;
            state_d[i] = HOLD;
          end
        end
        default: if (pick_v && pick == SEL_W'(i)) begin
          pend_d[i]  = 1'b0;
          state_d[i] = IDLE;
        end
      endcase
    end
  end
  assign rd_d = (32'(pif.rd_sel) < NUM_SLOTS) ? cnt_q[pif.rd_sel] : '0;
  assign ds_d = pick_v ? pick : ds_q;
  assign dc_d = pick_v ? snap_q[pick] : dc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_q   <= '0;
      state_q <= '{default: IDLE};
      cnt_q   <= '0;
      snap_q  <= '0;
      pend_q  <= '0;
      exp_q   <= '0;
      rd_q    <= '0;
      dv_q    <= 1'b0;
      ds_q    <= '0;
      dc_q    <= '0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
      exp_q   <= exp_d;
      rd_q    <= rd_d;
      dv_q    <= pick_v;
      ds_q    <= ds_d;
      dc_q    <= dc_d;
    end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_run
    assign pif.running[g] = state_q[g] == RUN;
  end
  assign pif.tick       = tick;
  assign pif.expired    = exp_q;
  assign pif.rd_count   = rd_q;
  assign pif.done_valid = dv_q;
  assign pif.done_slot  = ds_q;
  assign pif.done_count = dc_q;
endmodule

// File: doc/parking_timer_bank.md
Name: parking_timer_bank

Overview:
- Multi-slot parking-duration timer; a parametrised successor to the single free-running timer.
- A shared prescaler generates time ticks. Each slot has a start/stop-controlled counter with a sticky overstay (expiry) flag.
- Final durations are queued and reported one per cycle on a billing output for the fee/display logic.
- Sits between the gate/slot sensors and the billing/display blocks of the parking system.

Parameters:
- NUM_SLOTS, 4: number of parking slots (channels).
- SEL_W, 2: width of slot index fields; must satisfy 2^SEL_W >= NUM_SLOTS.
- CNT_W, 10: per-slot duration counter width.
- PRESCALE, 100: clock cycles per time tick; must be >= 2.
- MAX_TIME, 600: tick count at or above which a slot is flagged expired.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  NUM_SLOTS  one-cycle pulse per slot: car entered.
- stop  in  NUM_SLOTS  one-cycle pulse per slot: car left.
- rd_sel  in  SEL_W  slot index for the live count readout.
- rd_count  out  CNT_W  registered live count of slot rd_sel.
- tick  out  1  one-cycle prescaler pulse.
- running  out  NUM_SLOTS  slot currently timing.
- expired  out  NUM_SLOTS  sticky overstay flag.
- done_valid  out  1  one-cycle pulse: a final duration is presented.
- done_slot  out  SEL_W  slot index of the reported duration.
- done_count  out  CNT_W  final duration in ticks.

Behaviour:
- Reset (async, active-high):
  - Prescaler = 0; all slot states IDLE; counts, snapshots and pending bits = 0.
  - All outputs = 0.
  - Takes effect immediately, mid-operation included; no report survives it.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = 1 for exactly the cycle the prescaler equals PRESCALE-1.
  - The first tick after reset release occurs on the PRESCALE-th clock edge.
- Per-slot FSM, states IDLE, RUN, HOLD:
  - IDLE + start[i]: count <= 0, expired[i] <= 0, go to RUN. running[i] = 1 from the next cycle.
  - RUN + tick: count <= count+1, saturating at 2^CNT_W-1 (no wrap).
  - RUN: expired[i] is set when the updated count >= MAX_TIME; it stays set until the next accepted start or reset.
  - RUN + stop[i]: snapshot <= this cycle's updated count (includes a coincident tick increment); pending[i] <= 1; go to HOLD; running[i] <= 0.
  - HOLD: count frozen; start and stop ignored; returns to IDLE in the cycle its report is issued.
  - Ignored inputs: start in RUN (no restart); stop in IDLE.
  - start and stop on the same slot in the same cycle: in IDLE, start wins and stop is ignored; in RUN, stop wins.
- Reporter:
  - Each cycle, picks the lowest-index pending slot j.
  - Registers done_valid = 1, done_slot = j, done_count = snapshot[j]; clears pending[j].
  - Latency: stop sampled at edge N gives done_valid high during the cycle after edge N+1.
  - Simultaneous stops are reported on consecutive cycles in ascending index order; none are dropped.
  - done_slot and done_count hold their last values when done_valid = 0.
- Readout:
  - rd_count <= count[rd_sel], one-cycle latency.
  - rd_sel >= NUM_SLOTS gives rd_count = 0.
  - The count of an IDLE slot reads its last value (0 after reset).

Optional Feature:
- Macro PARKING_TIMER_PAUSE_EN.
- When defined: adds input port pause (1 bit, after rd_sel). While pause = 1 the prescaler holds its value and tick stays 0, so all RUN counts freeze. start, stop and the reporter still operate.
- When undefined: no pause port; the prescaler is free-running.

Test Plan:
- Bench overrides for all scenarios: NUM_SLOTS=4, CNT_W=4, PRESCALE=4, MAX_TIME=5.
- Reset held 20 ns, then released -> all outputs 0 during reset; tick pulses every 4 cycles, the first on the 4th edge after release.
- start[0] pulse, wait 3 ticks, stop[0] -> running[0] 1 then 0; done_valid for one cycle, 2 cycles after stop, with done_slot=0 and done_count=3.
- start[1], run 20 ticks -> expired[1] rises when count reaches 5; rd_sel=1 shows rd_count saturating at 15; stop[1] -> done_count=15, expired[1] remains 1 until the next start[1].
- Slots 2 and 3 at counts 2 and 4; stop[2] and stop[3] in the same cycle -> two consecutive done_valid cycles: (slot 2, 2) then (slot 3, 4).
- Slots 0 and 1 running; reset pulsed mid-run, asynchronously between edges -> running, counts and expired drop to 0 immediately; no done_valid after release; start ignored while reset = 1.
- With PARKING_TIMER_PAUSE_EN defined: slot 0 at count 2, pause held for 12 cycles -> no tick, count stays 2; ticks resume after release and stop[0] then reports the correct duration.
